// File: rtl/pulse_meter.sv
// Pulse-train meter: measures period and high time of pulse_in in clk cycles and
// classifies the duty ratio as 1/2, 1/3, 1/4 or 1/7 with the generators' floor(period/k) rule.
module pulse_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [1:0]       duty_mode,
  output logic             duty_match,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);
  localparam int PW = CNT_W + 3;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_lat_q, high_lat_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic [1:0]             duty_mode_q, duty_mode_d;
  logic                   duty_match_q, duty_match_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   timeout_q, timeout_d;
  logic                   s, rise, fall, at_limit;
  logic [1:0]             cls_mode;
  logic                   cls_match;
  logic [PW-1:0]          p_ext, h_ext;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d_q;
  assign fall     = ~s & s_d_q;
  assign at_limit = (cnt_q == TIMEOUT_VAL);

  // Synchronizer and edge history run in every state so a level already high at enable is no rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      s_d_q  <= s;
    end
  end

  function automatic logic fits(input logic [PW-1:0] p, input logic [PW-1:0] kh,
                                input logic [PW-1:0] slack);
    return (p >= kh) && ((p - kh) <= slack);
  endfunction

  // Candidate classification of the period that ends now; first match in 1/2,1/3,1/4,1/7 order.
  always_comb begin
    p_ext     = PW'(cnt_q);
    h_ext     = PW'(high_lat_q);
    cls_match = 1'b1;
    cls_mode  = 2'b00;
    if (fits(p_ext, h_ext << 1, PW'(1)))                  cls_mode = 2'b00;
    else if (fits(p_ext, (h_ext << 1) + h_ext, PW'(2)))   cls_mode = 2'b01;
    else if (fits(p_ext, h_ext << 2, PW'(3)))             cls_mode = 2'b10;
    else if (fits(p_ext, (h_ext << 3) - h_ext, PW'(6)))   cls_mode = 2'b11;
    else                                                  cls_match = 1'b0;
  end

  // NOTE: every _d is first given its hold value, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_lat_d   = high_lat_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    duty_mode_d  = duty_mode_q;
    duty_match_d = duty_match_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(1);
          end else if (at_limit) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HIGH: begin
          // Timeout is checked before the fall so cnt can never step past the limit.
          if (at_limit) begin
            state_d   = ARM;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
              high_lat_d = cnt_q;
              state_d    = LOW;
            end
          end
        end
        LOW: begin
          if (rise) begin
            period_d     = cnt_q;
            high_time_d  = high_lat_q;
            duty_mode_d  = cls_mode;
            duty_match_d = cls_match;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            cnt_d        = CNT_W'(1);
            state_d      = HIGH;
          end else if (at_limit) begin
            state_d   = ARM;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_lat_q   <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      duty_mode_q  <= 2'b00;
      duty_match_q <= 1'b0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_lat_q   <= high_lat_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      duty_mode_q  <= duty_mode_d;
      duty_match_q <= duty_match_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign duty_mode  = duty_mode_q;
  assign duty_match = duty_match_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == HIGH) || (state_q == LOW);
endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: expected measurements are queued as pulses are driven
// and compared when meas_valid strobes; timeout, enable-drop and async reset are checked inline.
module tb_pulse_meter;
  localparam int CNT_W = 16;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [1:0]       mode;
    logic             match;
    bit               chk_gap;
  } exp_t;

  logic             clk, rst_n, enable, pulse_in;
  logic [CNT_W-1:0] period, high_time;
  logic [1:0]       duty_mode;
  logic             duty_match, meas_valid, timeout, busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_strobe_cyc = -1;
  exp_t sb[$];

  int   prev_h, prev_l, chain_len;
  bit   prev_valid;

  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(100), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_in),
    .period(period), .high_time(high_time), .duty_mode(duty_mode),
    .duty_match(duty_match), .meas_valid(meas_valid), .timeout(timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference duty rule: mode k matches iff 0 <= p - k*h <= k-1, lowest k first.
  function automatic exp_t make_exp(input int h, input int l, input bit gap);
    exp_t e;
    int   ks[4];
    int   p;
    ks = '{2, 3, 4, 7};
    p  = h + l;
    e.period  = CNT_W'(p);
    e.high    = CNT_W'(h);
    e.mode    = 2'b00;
    e.match   = 1'b0;
    e.chk_gap = gap;
    for (int i = 3; i >= 0; i--)
      if ((p - ks[i] * h >= 0) && (p - ks[i] * h <= ks[i] - 1)) begin
        e.mode  = 2'(i);
        e.match = 1'b1;
      end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One period starting with a rise; that rise completes the previous period of the chain.
  task automatic drive_period(input int h, input int l);
    if (prev_valid) begin
      sb.push_back(make_exp(prev_h, prev_l, chain_len > 0));
      chain_len++;
    end
    pulse_in = 1'b1;
    tick(h);
    pulse_in = 1'b0;
    tick(l);
    prev_h     = h;
    prev_l     = l;
    prev_valid = 1'b1;
  endtask

  task automatic close_rise();
    if (prev_valid) sb.push_back(make_exp(prev_h, prev_l, chain_len > 0));
    pulse_in   = 1'b1;
    prev_valid = 1'b0;
    chain_len  = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      check("strobe_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("period", 32'(period), 32'(e.period));
        check("high_time", 32'(high_time), 32'(e.high));
        check("duty_mode", 32'(duty_mode), 32'(e.mode));
        check("duty_match", 32'(duty_match), 32'(e.match));
        check("timeout_clr", 32'(timeout), 0);
        if (e.chk_gap) check("strobe_gap", 32'(cyc - last_strobe_cyc), 32'(e.period));
      end
      last_strobe_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b0;
    pulse_in   = 1'b0;
    prev_valid = 1'b0;
    chain_len  = 0;
    prev_h     = 0;
    prev_l     = 0;
    #2 rst_n = 1'b0;
    tick(3);
    pulse_in = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_flags", {26'd0, duty_mode, duty_match, meas_valid, timeout, busy}, 0);
    pulse_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // T1..T4 back to back: 3 MHz square, 5 MHz 1/7, 10 MHz 1/3, unmatched 9/21
    enable = 1'b1;
    tick(4);
    check("arm_not_busy", 32'(busy), 0);
    repeat (5) drive_period(16, 17);
    check("t1_busy", 32'(busy), 1);
    repeat (3) drive_period(2, 18);
    repeat (3) drive_period(3, 7);
    repeat (3) drive_period(9, 21);

    // T5: rise then held high -> timeout 100 clk after the rise reaches the FSM
    close_rise();
    tick(102);
    @(negedge clk);
    check("t5_timeout_early", 32'(timeout), 0);
    tick(1);
    @(negedge clk);
    check("t5_timeout_set", 32'(timeout), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_period_hold", 32'(period), 30);
    check("t5_high_hold", 32'(high_time), 9);
    check("t5_match_hold", {30'd0, duty_mode, duty_match}, 0);
    tick(1);
    pulse_in = 1'b0;
    tick(5);
    drive_period(16, 17);
    check("t5_timeout_sticky", 32'(timeout), 1);
    drive_period(16, 17);
    check("t5_timeout_cleared", 32'(timeout), 0);
    drive_period(16, 17);

    // T6: drop enable mid-HIGH, then re-enable with the input already high
    close_rise();
    tick(8);
    check("t6_busy_high", 32'(busy), 1);
    enable = 1'b0;
    tick(1);
    @(negedge clk);
    check("t6_busy_off", 32'(busy), 0);
    check("t6_timeout_off", 32'(timeout), 0);
    tick(40);
    check("t6_period_hold", 32'(period), 33);
    check("t6_high_hold", 32'(high_time), 16);
    check("t6_duty_hold", {30'd0, duty_mode, duty_match}, 1);
    enable = 1'b1;
    tick(20);
    check("t6_wait_rise", 32'(busy), 0);
    pulse_in = 1'b0;
    tick(10);
    check("t6_still_armed", 32'(busy), 0);
    drive_period(16, 17);
    drive_period(16, 17);

    // T7: asynchronous reset in the middle of LOW
    close_rise();
    tick(16);
    pulse_in = 1'b0;
    tick(8);
    check("t7_busy_low", 32'(busy), 1);
    check("t7_period_pre", 32'(period), 33);
    #2 rst_n = 1'b0;
    #1;
    check("t7_period", 32'(period), 0);
    check("t7_high", 32'(high_time), 0);
    check("t7_flags", {26'd0, duty_mode, duty_match, meas_valid, timeout, busy}, 0);
    #1 rst_n = 1'b1;
    tick(3);
    check("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
